// File: rtl/serv_rf_ram_bridge.sv
// rtl/serv_rf_ram_bridge.sv - SERV bit-serial register file to WIDTH-bit dual-port RAM bridge
module serv_rf_ram_bridge #(
  parameter int WIDTH = 2,
  localparam int LW = $clog2(WIDTH),
  localparam int WB = 5 - LW,
  localparam int AW = 6 + WB
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_rf_rreq,
  input  logic             i_rf_wreq,
  output logic             o_rf_ready,
  input  logic [5:0]       i_rreg0,
  input  logic [5:0]       i_rreg1,
  output logic             o_rdata0,
  output logic             o_rdata1,
  input  logic [5:0]       i_wreg0,
  input  logic [5:0]       i_wreg1,
  input  logic             i_wen0,
  input  logic             i_wen1,
  input  logic             i_wdata0,
  input  logic             i_wdata1,
  output logic [AW-1:0]    o_ram_raddr,
  output logic             o_ram_ren,
  input  logic [WIDTH-1:0] i_ram_rdata,
  output logic [AW-1:0]    o_ram_waddr,
  output logic [WIDTH-1:0] o_ram_wdata,
  output logic             o_ram_wen
);
  typedef enum logic [1:0] {IDLE, RSETUP, STREAM, WDRAIN} state_t;

  state_t           r_state, w_next;
  logic [5:0]       r_p;
  logic             r_rd, r_wr;
  logic [5:0]       r_rreg0, r_rreg1, r_wreg0, r_wreg1;
  logic [WIDTH-1:0] r_hold0, r_rsh0, r_rsh1, r_wsh0, r_wsh1, r_p1_data;
  logic             r_rv0, r_rv1, r_p1_pend, r_p1_en;
  logic [AW-1:0]    r_p1_addr;
  logic [5:0]       w_soff, w_bit;
  logic             w_setup_end, w_wlast, w_accept;
  logic             w_stream, w_sel0, w_sel1, w_ren;

  // r_p counts cycles since the request; stream bit index is r_p minus the setup length
  assign w_soff      = r_rd ? 6'd3 : 6'd1;
  assign w_bit       = r_p - w_soff;
  assign w_setup_end = (r_p == w_soff - 6'd1);
  assign w_wlast     = (w_bit[LW-1:0] == {LW{1'b1}});
  assign w_accept    = (r_state == IDLE) && (i_rf_rreq || i_rf_wreq);

  always_ff @(posedge clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_rf_rreq || i_rf_wreq) w_next = RSETUP;
      RSETUP:  if (w_setup_end) w_next = STREAM;
      STREAM:  if (w_bit == 6'd31) w_next = r_wr ? WDRAIN : IDLE;
      WDRAIN:  if (w_bit == 6'd33) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // rs0 word j is read two cycles and rs1 word j one cycle before both shift registers reload
  always_comb begin
    w_stream    = (r_state == STREAM);
    o_rf_ready  = (r_state == RSETUP) && w_setup_end;
    w_sel0      = (r_p[LW-1:0] == '0);
    w_sel1      = (r_p[LW-1:0] == LW'(1));
    w_ren       = r_rd && ((r_state == RSETUP) || w_stream) && !r_p[5] && (w_sel0 || w_sel1);
    o_ram_ren   = w_ren;
    o_ram_raddr = w_ren ? {(w_sel0 ? r_rreg0 : r_rreg1), r_p[4:LW]} : '0;
    o_rdata0    = w_stream && r_rd && r_rsh0[0];
    o_rdata1    = w_stream && r_rd && r_rsh1[0];
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_p         <= '0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_rreg0     <= '0;
      r_rreg1     <= '0;
      r_wreg0     <= '0;
      r_wreg1     <= '0;
      r_rv0       <= 1'b0;
      r_rv1       <= 1'b0;
      r_hold0     <= '0;
      r_rsh0      <= '0;
      r_rsh1      <= '0;
      r_wsh0      <= '0;
      r_wsh1      <= '0;
      r_p1_pend   <= 1'b0;
      r_p1_en     <= 1'b0;
      r_p1_data   <= '0;
      r_p1_addr   <= '0;
      o_ram_wen   <= 1'b0;
      o_ram_waddr <= '0;
      o_ram_wdata <= '0;
    end else begin
      if (w_accept) begin
        r_p     <= '0;
        r_rd    <= i_rf_rreq;
        r_wr    <= i_rf_wreq;
        r_rreg0 <= i_rreg0;
        r_rreg1 <= i_rreg1;
        r_wreg0 <= i_wreg0;
        r_wreg1 <= i_wreg1;
      end else if (r_state != IDLE) begin
        r_p <= r_p + 6'd1;
      end
      r_rv0 <= w_ren && w_sel0;
      r_rv1 <= w_ren && w_sel1;
      if (r_rv0) r_hold0 <= i_ram_rdata;
      if (r_rv1) begin
        r_rsh0 <= (r_rreg0 == 6'd0) ? '0 : r_hold0;
        r_rsh1 <= (r_rreg1 == 6'd0) ? '0 : i_ram_rdata;
      end else begin
        r_rsh0 <= r_rsh0 >> 1;
        r_rsh1 <= r_rsh1 >> 1;
      end
      if (w_stream && r_wr) begin
        r_wsh0 <= {i_wdata0, r_wsh0[WIDTH-1:1]};
        r_wsh1 <= {i_wdata1, r_wsh1[WIDTH-1:1]};
      end
      // port1 word is parked one cycle so the write port alternates port0/port1
      if (w_stream && r_wr && w_wlast) begin
        o_ram_wen   <= i_wen0 && (r_wreg0 != 6'd0);
        o_ram_waddr <= {r_wreg0, w_bit[4:LW]};
        o_ram_wdata <= {i_wdata0, r_wsh0[WIDTH-1:1]};
        r_p1_pend   <= 1'b1;
        r_p1_en     <= i_wen1 && (r_wreg1 != 6'd0);
        r_p1_addr   <= {r_wreg1, w_bit[4:LW]};
        r_p1_data   <= {i_wdata1, r_wsh1[WIDTH-1:1]};
      end else if (r_p1_pend) begin
        o_ram_wen   <= r_p1_en;
        o_ram_waddr <= r_p1_addr;
        o_ram_wdata <= r_p1_data;
        r_p1_pend   <= 1'b0;
      end else begin
        o_ram_wen   <= 1'b0;
      end
    end
  end
endmodule
